// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, requester port ids, bytes per RAM word and
// the helper that computes the highest legal start address of a word access.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester ids; also the encoding stored in last_grant.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // One access moves a whole 64-bit word.
    localparam int unsigned WORD_BYTES = 8;

    // Highest start address whose full word still lies inside the RAM.
    // Anything above it would index past the end of the array.
    function automatic int unsigned bound_limit(input int unsigned mem_depth,
                                                input int unsigned word_bytes);
        return mem_depth - word_bytes;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Latency: 0 cycles (grant follows the valids in the same cycle).
// Backpressure: none; the caller qualifies the grant with its own state.
//
// Ports:
//   req0/req1   request valids of port 0 (fetch) and port 1 (data)
//   last_grant  id of the port granted most recently
//   gnt0/gnt1   one-hot grant (both low when nobody requests)
//   gnt_id      id of the granted port (meaningful only when a grant exists)
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            // Contention: the port that did not win last time goes first.
            if (last_grant == PORT_D) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign gnt_id = gnt1 ? PORT_D : PORT_IF;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-addressed 64-bit big-endian RAM between instruction fetch and data.
// Latency: accept edge -> ACCESS cycle -> response pulse in the following (RESP) cycle.
// Backpressure: valid/ready; ready is offered in IDLE and RESP only, so at most one request per 2 cycles.
//
// Ports:
//   clk, reset                   clock (rising edge), asynchronous active-high reset
//   if_req_valid/ready, if_addr  fetch request (read-only)
//   if_resp_valid/err, if_rdata  fetch response pulse
//   d_req_valid/ready, d_req_write, d_addr, d_wdata   data request
//   d_resp_valid/err, d_rdata    data response pulse (read data or write ack)
//   ram_address, ram_is_reading, ram_data_in, ram_data_out   RAM pins (dataOut registered)
//   busy                         high whenever the FSM is not IDLE
//
// Build option: define RAM_ARBITER_ALIGN_CHECK_EN to also reject addresses that
// are not word aligned (addr[2:0] != 0). Without it only the bounds check applies.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = 11,
    parameter int unsigned MEM_DEPTH     = 2 ** ADDRESS_SIZE,
    parameter int unsigned MEM_WORD_SIZE = 8 * WORD_BYTES
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     if_req_valid,
    output logic                     if_req_ready,
    input  logic [ADDRESS_SIZE-1:0]  if_addr,
    output logic                     if_resp_valid,
    output logic [MEM_WORD_SIZE-1:0] if_rdata,
    output logic                     if_resp_err,

    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    input  logic                     d_req_write,
    input  logic [ADDRESS_SIZE-1:0]  d_addr,
    input  logic [MEM_WORD_SIZE-1:0] d_wdata,
    output logic                     d_resp_valid,
    output logic [MEM_WORD_SIZE-1:0] d_rdata,
    output logic                     d_resp_err,

    output logic [ADDRESS_SIZE-1:0]  ram_address,
    output logic                     ram_is_reading,
    output logic [MEM_WORD_SIZE-1:0] ram_data_in,
    input  logic [MEM_WORD_SIZE-1:0] ram_data_out,

    output logic                     busy
);

    localparam int unsigned ADDR_LIMIT = bound_limit(MEM_DEPTH, WORD_BYTES);

    state_t state;
    state_t state_nxt;

    // Request context captured on the accept edge. ram_address and
    // ram_data_in are themselves part of it and drive the RAM directly.
    logic last_grant;
    logic lat_port;
    logic lat_write;
    logic lat_err;

    logic offer;        // FSM is in a state that may take a new request
    logic gnt_if;
    logic gnt_d;
    logic gnt_id;
    logic accept;

    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic                    sel_write;
    logic                    sel_err;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    rr_arbiter2 u_arb (
        .req0       (if_req_valid),
        .req1       (d_req_valid),
        .last_grant (last_grant),
        .gnt0       (gnt_if),
        .gnt1       (gnt_d),
        .gnt_id     (gnt_id)
    );

    assign if_req_ready = offer && gnt_if;
    assign d_req_ready  = offer && gnt_d;
    assign accept       = if_req_ready || d_req_ready;

    assign sel_addr  = gnt_d ? d_addr : if_addr;
    // The fetch port has no write strobe; only the data port can write.
    assign sel_write = gnt_d && d_req_write;

    // A rejected request still walks through ACCESS/RESP so both outcomes
    // share one latency; it just never lowers ram_is_reading.
    always_comb begin
        sel_err = (32'(sel_addr) > ADDR_LIMIT);
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
        sel_err = sel_err || (sel_addr[2:0] != 3'd0);
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = accept ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            // A request taken while the response issues goes straight to
            // ACCESS, which is what gives one request every two cycles.
            RESP:    state_nxt = accept ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        offer          = 1'b0;
        ram_is_reading = 1'b1;
        if_resp_valid  = 1'b0;
        d_resp_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                offer = 1'b1;
            end
            ACCESS: begin
                // The RAM writes on any edge where this pin is low, so it
                // drops only for a legal write. Because it decodes the state
                // register, reset raises it asynchronously and aborts an
                // in-flight write.
                ram_is_reading = !(lat_write && !lat_err);
            end
            RESP: begin
                offer         = 1'b1;
                if_resp_valid = (lat_port == PORT_IF);
                d_resp_valid  = (lat_port == PORT_D);
            end
            default: begin
                offer = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Response payload: zero on the idle port, zero for rejected requests,
    // and zero as the (don't-care) data of a write acknowledge.
    assign if_resp_err = if_resp_valid && lat_err;
    assign d_resp_err  = d_resp_valid && lat_err;
    assign if_rdata    = (if_resp_valid && !lat_err) ? ram_data_out : '0;
    assign d_rdata     = (d_resp_valid && !lat_err && !lat_write) ? ram_data_out : '0;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    // last_grant resets to the data port so fetch wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= PORT_D;
            lat_port    <= PORT_IF;
            lat_write   <= 1'b0;
            lat_err     <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else if (accept) begin
            last_grant  <= gnt_id;
            lat_port    <= gnt_id;
            lat_write   <= sel_write;
            lat_err     <= sel_err;
            ram_address <= sel_addr;
            ram_data_in <= gnt_d ? d_wdata : '0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int DEPTH = 2048;
    localparam int LIMIT = DEPTH - 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [10:0] if_addr;
    logic [63:0] if_rdata;
    logic        d_req_valid, d_req_ready, d_req_write, d_resp_valid, d_resp_err;
    logic [10:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic [10:0] ram_address;
    logic        ram_is_reading;
    logic [63:0] ram_data_in;
    logic [63:0] ram_data_out = 64'd0;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_low = 0;
    int resp_cnt = 0;

    typedef struct {
        bit          port;
        bit          wr;
        bit          err;
        logic [10:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   grant_q[$];
    int   acc_q[$];

    logic [7:0] ram_mem [0:DEPTH-1] = '{default: 8'h00};
    logic [7:0] model   [0:DEPTH-1] = '{default: 8'h00};

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid),
        .d_rdata(d_rdata), .d_resp_err(d_resp_err),
        .ram_address(ram_address), .ram_is_reading(ram_is_reading),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: big-endian word at a byte address, registered read.
    function automatic logic [63:0] ram_rd(input int a);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 8; i++) r = {r[55:0], (a + i < DEPTH) ? ram_mem[a + i] : 8'h00};
        return r;
    endfunction

    always @(posedge clk) begin
        if (!ram_is_reading) begin
            for (int i = 0; i < 8; i++)
                if (int'(ram_address) + i < DEPTH)
                    ram_mem[int'(ram_address) + i] <= ram_data_in[63 - 8 * i -: 8];
        end
        ram_data_out <= ram_rd(int'(ram_address));
    end

    function automatic logic [63:0] model_rd(input int a);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 8; i++) r = {r[55:0], (a + i < DEPTH) ? model[a + i] : 8'h00};
        return r;
    endfunction

    function automatic bit exp_err(input logic [10:0] a);
        bit r = (int'(a) > LIMIT);
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
        r = r || (a[2:0] != 3'd0);
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input bit p, input bit wr, input logic [10:0] a, input logic [63:0] wd);
        exp_t e;
        e.port  = p;
        e.wr    = p && wr;
        e.err   = exp_err(a);
        e.addr  = a;
        e.wdata = wd;
        e.rdata = e.err ? 64'd0 : model_rd(int'(a));
        e.acc   = cyc;
        exp_q.push_back(e);
        grant_q.push_back(p);
        acc_q.push_back(cyc);
    endtask

    // Scoreboard: responses are retired before new accepts are recorded so a
    // write acked in RESP is visible to a read accepted on the same edge.
    // A write reaches the model only when acked, so an aborted one never does.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (!ram_is_reading) wr_low++;
            if (if_resp_valid || d_resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(if_resp_valid | d_resp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_port", 64'(d_resp_valid), 64'(mon_e.port));
                    check("resp_single", 64'(if_resp_valid & d_resp_valid), 64'd0);
                    check("latency", 64'(cyc - mon_e.acc), 64'd2);
                    if (mon_e.port) begin
                        check("d_err", 64'(d_resp_err), 64'(mon_e.err));
                        if (!mon_e.wr) check("d_rdata", d_rdata, mon_e.rdata);
                        check("if_idle_zero", if_rdata | 64'(if_resp_err), 64'd0);
                        if (mon_e.wr && !mon_e.err)
                            for (int i = 0; i < 8; i++)
                                model[int'(mon_e.addr) + i] = mon_e.wdata[63 - 8 * i -: 8];
                    end else begin
                        check("if_err", 64'(if_resp_err), 64'(mon_e.err));
                        check("if_rdata", if_rdata, mon_e.rdata);
                        check("d_idle_zero", d_rdata | 64'(d_resp_err), 64'd0);
                    end
                end
            end
            if (if_req_valid && if_req_ready) push_exp(1'b0, 1'b0, if_addr, 64'd0);
            if (d_req_valid && d_req_ready) push_exp(1'b1, d_req_write, d_addr, d_wdata);
        end
    end

    // Present one request (called at posedge+1), hold until accepted.
    task automatic do_req(input bit p, input bit wr, input logic [10:0] a, input logic [63:0] wd);
        bit got = 1'b0;
        if (p) begin
            d_req_valid = 1'b1; d_req_write = wr; d_addr = a; d_wdata = wd;
        end else begin
            if_req_valid = 1'b1; if_addr = a;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = p ? d_req_ready : if_req_ready;
            @(posedge clk);
            #1;
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        check("accept", 64'(got), 64'd1);
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int wl0;
        int rc0;
        int base;
        int k_if;
        int k_d;
        bit a_if;
        bit a_d;

        reset = 1'b1;
        if_req_valid = 1'b1; if_addr = 11'h0;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_addr = 11'h0; d_wdata = 64'd0;
        #12;
        // Reset state; with both valid, fetch wins first.
        check("rst_is_reading", 64'(ram_is_reading), 64'd1);
        check("rst_address", 64'(ram_address), 64'd0);
        check("rst_data_in", ram_data_in, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp", 64'({if_resp_valid, if_resp_err, d_resp_valid, d_resp_err}), 64'd0);
        check("rst_if_ready", 64'(if_req_ready), 64'd1);
        check("rst_d_ready", 64'(d_req_ready), 64'd0);
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write then fetch the same word; exactly one write cycle.
        wl0 = wr_low;
        do_req(1'b1, 1'b1, 11'h010, 64'h0123456789ABCDEF);
        wait_drain();
        do_req(1'b0, 1'b0, 11'h010, 64'd0);
        wait_drain();
        check("write_low_cycles", 64'(wr_low - wl0), 64'd1);

        // Data read presented during a fetch's ACCESS, taken in its RESP.
        do_req(1'b0, 1'b0, 11'h000, 64'd0);
        d_req_valid = 1'b1; d_req_write = 1'b0; d_addr = 11'h018;
        @(negedge clk);
        check("no_ready_in_access", 64'(d_req_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_in_resp", 64'(d_req_ready), 64'd1);
        check("resp_with_accept", 64'(if_resp_valid), 64'd1);
        check("busy_in_resp", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        wait_drain();
        check("no_idle_gap", 64'(acc_q[$] - acc_q[$-1]), 64'd2);

        // Both ports continuously valid: strict alternation starting with fetch.
        base = grant_q.size();
        k_if = 0;
        k_d = 0;
        if_req_valid = 1'b1; if_addr = 11'h000;
        d_req_valid = 1'b1; d_req_write = 1'b1; d_addr = 11'h000; d_wdata = 64'h0F1E2D3C4B5A6978;
        for (int c = 0; c < 40 && (k_if < 3 || k_d < 3); c++) begin
            @(negedge clk);
            a_if = if_req_valid && if_req_ready;
            a_d  = d_req_valid && d_req_ready;
            check("one_ready", 64'(if_req_ready & d_req_ready), 64'd0);
            @(posedge clk);
            #1;
            if (a_if) begin
                k_if++;
                if (k_if < 3) if_addr = 11'(8 * k_if);
                else if_req_valid = 1'b0;
            end
            if (a_d) begin
                k_d++;
                if (k_d < 3) begin
                    d_addr = 11'(8 * k_d);
                    d_wdata = 64'h0F1E2D3C4B5A6978 + 64'(k_d);
                end else begin
                    d_req_valid = 1'b0;
                end
            end
        end
        check("alt_count", 64'(k_if + k_d), 64'd6);
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            check("alt_grant", 64'(grant_q[base + i]), 64'(i % 2));
            if (i > 0) check("alt_spacing", 64'(acc_q[base + i] - acc_q[base + i - 1]), 64'd2);
        end

        // Out-of-range write is rejected and never writes; neighbours intact.
        wl0 = wr_low;
        do_req(1'b1, 1'b1, 11'h7F9, 64'hDEADBEEFCAFEF00D);
        wait_drain();
        check("oob_no_write", 64'(wr_low - wl0), 64'd0);
        do_req(1'b1, 1'b0, 11'h7F8, 64'd0);
        wait_drain();
        do_req(1'b0, 1'b0, 11'h7F9, 64'd0);
        wait_drain();

        // Reset during the ACCESS cycle of a write aborts it.
        do_req(1'b1, 1'b1, 11'h020, 64'hA5A5A5A5A5A5A5A5);
        check("access_write_low", 64'(ram_is_reading), 64'd0);
        rc0 = resp_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("abort_is_reading", 64'(ram_is_reading), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_resp", 64'(resp_cnt - rc0), 64'd0);
        do_req(1'b1, 1'b0, 11'h020, 64'd0);
        wait_drain();

        // Unaligned read: rejected only when the alignment check is built in.
        do_req(1'b1, 1'b0, 11'h004, 64'd0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
